// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit (master) and the mul/div sequencer (slave).
// start_mult/start_div are levels; the sequencer samples them only on an edge where it can accept.
interface muldiv_sequencer_if;
  logic       start_mult;
  logic       start_div;
  logic       divisor_zero;
  logic       mult_init;
  logic       div_init;
  logic       hilo_sel;
  logic       hi_load;
  logic       lo_load;
  logic       busy;
  logic       done;
  logic       div_zero_exc;
  logic [5:0] cycle_count;

  modport master (
    output start_mult, start_div, divisor_zero,
    input  mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done,
           div_zero_exc, cycle_count
  );

  modport slave (
    input  start_mult, start_div, divisor_zero,
    output mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done,
           div_zero_exc, cycle_count
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Issues init pulses to the shared multiplier/divider, counts their fixed latency,
// then loads HI/LO and pulses done; divide-by-zero raises an exception instead.
module muldiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MULT_RUN  = 3'd1,
    DIV_RUN   = 3'd2,
    WRITEBACK = 3'd3,
    DONE      = 3'd4,
    DZ_EXC    = 3'd5
  } state_t;

  // WIDTH only documents the operand size; it never gates the load values.
  localparam logic [5:0] MULT_LOAD = (WIDTH > 0) ? 6'(MULT_CYCLES - 1) : 6'd0;
  localparam logic [5:0] DIV_LOAD  = (WIDTH > 0) ? 6'(DIV_CYCLES - 1)  : 6'd0;

  state_t     state;
  logic [5:0] counter;

  assign fsm_state       = state;
  assign bus.cycle_count = counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      counter          <= 6'd0;
      bus.mult_init    <= 1'b0;
      bus.div_init     <= 1'b0;
      bus.hilo_sel     <= 1'b0;
      bus.hi_load      <= 1'b0;
      bus.lo_load      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.div_zero_exc <= 1'b0;
    end else begin
      bus.mult_init    <= 1'b0;
      bus.div_init     <= 1'b0;
      bus.hi_load      <= 1'b0;
      bus.lo_load      <= 1'b0;
      bus.done         <= 1'b0;
      bus.div_zero_exc <= 1'b0;

      case (state)
        // DONE accepts like IDLE so back-to-back issue loses no cycle.
        IDLE, DONE: begin
          if (bus.start_mult) begin
            state         <= MULT_RUN;
            counter       <= MULT_LOAD;
            bus.mult_init <= 1'b1;
            bus.hilo_sel  <= 1'b1;
            bus.busy      <= 1'b1;
          end else if (bus.start_div && bus.divisor_zero) begin
            state            <= DZ_EXC;
            bus.div_zero_exc <= 1'b1;
            bus.busy         <= 1'b0;
          end else if (bus.start_div) begin
            state        <= DIV_RUN;
            counter      <= DIV_LOAD;
            bus.div_init <= 1'b1;
            bus.hilo_sel <= 1'b0;
            bus.busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        MULT_RUN, DIV_RUN: begin
          bus.busy <= 1'b1;
          if (counter == 6'd0) begin
            state       <= WRITEBACK;
            bus.hi_load <= 1'b1;
            bus.lo_load <= 1'b1;
          end else begin
            counter <= counter - 6'd1;
          end
        end

        WRITEBACK: begin
          state    <= DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end

        DZ_EXC: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          counter  <= 6'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
